// File: rtl/filter_pkg.sv
// filter_pkg
// Shared types and helpers for the per-pixel filter chain.
//   IMG_WIDTH_DEF / IMG_HEIGHT_DEF : default source image size
//   rgb565_t / rgb444_t            : packed pixel formats
//   rgb565_to_444()                : keeps the top 4 bits of each channel
//   addr_width()                   : frame-buffer address width for a WxH image
package filter_pkg;

   localparam int unsigned IMG_WIDTH_DEF  = 160;
   localparam int unsigned IMG_HEIGHT_DEF = 120;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   function automatic rgb444_t rgb565_to_444(input rgb565_t px);
      rgb444_t o;
      o.r = px.r[4:1];
      o.g = px.g[5:2];
      o.b = px.b[4:1];
      return o;
   endfunction

   function automatic int unsigned addr_width(input int unsigned w, input int unsigned h);
      return $clog2(w * h);
   endfunction

endpackage

// File: rtl/pipe_delay.sv
// pipe_delay
// Fixed-length register chain with synchronous active-high reset that
// clears every stage.
//   clk   : clock
//   reset : synchronous, active-high; flushes the chain to 0
//   din   : WIDTH-bit input
//   dout  : din delayed by DEPTH cycles (DEPTH >= 1)
module pipe_delay #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_window_reader.sv
// frame_window_reader
// Maps VGA raster coordinates onto an upscaled image window, generates
// sequential frame-buffer read addresses from counters (no multiplier), and
// returns RGB444 plus image-local coordinates with a fixed 2-cycle latency.
//   clk, reset            : pixel clock, synchronous active-high reset
//   x_pixel, y_pixel, DE  : raster position and display enable
//   h_sync, v_sync        : raster syncs, delayed 2 cycles to h_sync_o/v_sync_o
//   fb_addr, fb_rd_en     : frame-buffer read port (stage 1)
//   fb_rdata              : RGB565 from the RAM, valid one cycle after fb_addr
//   x_local, y_local      : source-image column/row of the output pixel
//   win_valid             : output pixel is inside the window and block synced
//   r_out, g_out, b_out   : RGB444, black when win_valid is low
module frame_window_reader
   import filter_pkg::*;
#(
   parameter  int unsigned WIN_X0      = 0,
   parameter  int unsigned WIN_Y0      = 0,
   parameter  int unsigned IMG_WIDTH   = IMG_WIDTH_DEF,
   parameter  int unsigned IMG_HEIGHT  = IMG_HEIGHT_DEF,
   parameter  int unsigned SCALE_SHIFT = 1,
   localparam int unsigned ADDR_W      = addr_width(IMG_WIDTH, IMG_HEIGHT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [9:0]        x_pixel,
   input  logic [9:0]        y_pixel,
   input  logic              DE,
   input  logic              h_sync,
   input  logic              v_sync,
   input  logic [15:0]       fb_rdata,
   output logic [ADDR_W-1:0] fb_addr,
   output logic              fb_rd_en,
   output logic [9:0]        x_local,
   output logic [9:0]        y_local,
   output logic              win_valid,
   output logic [3:0]        r_out,
   output logic [3:0]        g_out,
   output logic [3:0]        b_out,
   output logic              h_sync_o,
   output logic              v_sync_o
);

   localparam int unsigned X_SPAN = IMG_WIDTH << SCALE_SHIFT;
   localparam int unsigned Y_SPAN = IMG_HEIGHT << SCALE_SHIFT;
   // Sub-pixel counters keep at least one bit so SCALE_SHIFT = 0 still elaborates.
   localparam int unsigned SW     = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;

   localparam logic [SW-1:0]     SUB_MAX  = SW'((1 << SCALE_SHIFT) - 1);
   localparam logic [9:0]        X_FIRST  = 10'(WIN_X0);
   localparam logic [9:0]        Y_FIRST  = 10'(WIN_Y0);
   localparam logic [9:0]        X_LAST   = 10'(WIN_X0 + X_SPAN - 1);
   localparam logic [9:0]        LAST_COL = 10'(IMG_WIDTH - 1);
   localparam logic [9:0]        LAST_ROW = 10'(IMG_HEIGHT - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_WIDTH);

   // Window test on offsets: a pixel left of / above the window wraps to a
   // large value, so one unsigned compare covers both bounds.
   logic [11:0] x_off, y_off;
   logic        in_geo, at_origin, line_first, line_last, eff_win;

   logic [SW-1:0]     sub_x_q, sub_y_q;
   logic [9:0]        col_q, row_q;
   logic [ADDR_W-1:0] row_base_q;
   logic              synced_q;

   logic [SW-1:0]     cur_sub_x, cur_sub_y, sub_x_d, sub_y_d;
   logic [9:0]        cur_col, cur_row, col_d, row_d;
   logic [ADDR_W-1:0] cur_base, row_base_d, rd_addr;

   logic [ADDR_W-1:0] fb_addr_q;
   logic              fb_rd_en_q;
   logic [9:0]        x_s1_q, y_s1_q;
   logic              valid_s1_q;

   rgb444_t pix;

   assign x_off      = {2'b00, x_pixel} - 12'(WIN_X0);
   assign y_off      = {2'b00, y_pixel} - 12'(WIN_Y0);
   assign in_geo     = DE && (x_off < 12'(X_SPAN)) && (y_off < 12'(Y_SPAN));
   assign line_first = (x_pixel == X_FIRST);
   assign line_last  = (x_pixel == X_LAST);
   assign at_origin  = line_first && (y_pixel == Y_FIRST);
   // The origin pixel itself is processed on the same cycle it sets the sync flag.
   assign eff_win    = in_geo && (synced_q || at_origin);

   always_comb begin
      // Counter values that apply to the current pixel, after line/frame loads.
      cur_sub_x = line_first ? '0 : sub_x_q;
      cur_col   = line_first ? '0 : col_q;
      cur_sub_y = at_origin  ? '0 : sub_y_q;
      cur_row   = at_origin  ? '0 : row_q;
      cur_base  = at_origin  ? '0 : row_base_q;

      rd_addr = cur_base + ADDR_W'(cur_col);

      sub_x_d = (cur_sub_x == SUB_MAX) ? '0 : cur_sub_x + 1'b1;
      col_d   = cur_col;
      if ((cur_sub_x == SUB_MAX) && (cur_col != LAST_COL)) begin
         col_d = cur_col + 10'd1;
      end

      sub_y_d    = cur_sub_y;
      row_d      = cur_row;
      row_base_d = cur_base;
      if (line_last) begin
         sub_y_d = (cur_sub_y == SUB_MAX) ? '0 : cur_sub_y + 1'b1;
         // Hold on the last row so the counters stay put until the next frame load.
         if ((cur_sub_y == SUB_MAX) && (cur_row != LAST_ROW)) begin
            row_d      = cur_row + 10'd1;
            row_base_d = cur_base + ROW_STEP;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         synced_q   <= 1'b0;
         sub_x_q    <= '0;
         sub_y_q    <= '0;
         col_q      <= '0;
         row_q      <= '0;
         row_base_q <= '0;
         fb_addr_q  <= '0;
         fb_rd_en_q <= 1'b0;
         x_s1_q     <= '0;
         y_s1_q     <= '0;
         valid_s1_q <= 1'b0;
      end else begin
         fb_rd_en_q <= eff_win;
         valid_s1_q <= eff_win;
         x_s1_q     <= eff_win ? cur_col : 10'd0;
         y_s1_q     <= eff_win ? cur_row : 10'd0;
         if (eff_win) begin
            synced_q   <= 1'b1;
            fb_addr_q  <= rd_addr;
            sub_x_q    <= sub_x_d;
            col_q      <= col_d;
            sub_y_q    <= sub_y_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
         end
      end
   end

   assign fb_addr  = fb_addr_q;
   assign fb_rd_en = fb_rd_en_q;

   pipe_delay #(
      .WIDTH (21),
      .DEPTH (1)
   ) u_coord_delay (
      .clk   (clk),
      .reset (reset),
      .din   ({valid_s1_q, x_s1_q, y_s1_q}),
      .dout  ({win_valid, x_local, y_local})
   );

   pipe_delay #(
      .WIDTH (2),
      .DEPTH (2)
   ) u_sync_delay (
      .clk   (clk),
      .reset (reset),
      .din   ({h_sync, v_sync}),
      .dout  ({h_sync_o, v_sync_o})
   );

   // The RAM's own output register is the stage-2 pixel register; gating with
   // the delayed valid keeps out-of-window and flushed pixels black.
   assign pix   = rgb565_to_444(fb_rdata);
   assign r_out = win_valid ? pix.r : 4'h0;
   assign g_out = win_valid ? pix.g : 4'h0;
   assign b_out = win_valid ? pix.b : 4'h0;

endmodule

// File: doc/frame_window_reader.md
# frame_window_reader

Upstream feeder for the per-pixel filter stages (ASCII, etc.). It maps VGA raster coordinates onto a 2^SCALE_SHIFT-upscaled IMG_WIDTH×IMG_HEIGHT display window and generates sequential frame-buffer read addresses with incremental counters. It converts the returned RGB565 word to RGB444 and emits it with image-local coordinates `x_local` / `y_local` on a fixed 2-cycle pipeline, alongside delayed sync signals.

## Interface
- WIN_X0, 0: display x of window left edge
- WIN_Y0, 0: display y of window top edge
- IMG_WIDTH, 160: source image width (pixels)
- IMG_HEIGHT, 120: source image height (pixels)
- SCALE_SHIFT, 1: each source pixel is drawn 2^SCALE_SHIFT × 2^SCALE_SHIFT on screen
- clk  in  1  pixel clock (25 MHz); the only clock
- reset  in  1  synchronous, active-high reset
- x_pixel  in  10  raster x from VGA timing generator
- y_pixel  in  10  raster y
- DE  in  1  display enable
- h_sync, v_sync  in  1  raster syncs
- fb_rdata  in  16  RGB565 from synchronous frame-buffer RAM; valid 1 cycle after fb_addr
- fb_addr  out  ADDR_W=$clog2(IMG_WIDTH*IMG_HEIGHT)  frame-buffer read address
- fb_rd_en  out  1  read strobe, high only for in-window pixels
- x_local, y_local  out  10  source-image coordinates, aligned with RGB out
- win_valid  out  1  output pixel lies in window and block is synced
- r_out, g_out, b_out  out  4  RGB444
- h_sync_o, v_sync_o  out  1  syncs delayed by 2 cycles

## Operation
- Window: in_win = DE && WIN_X0 ≤ x_pixel < WIN_X0+IMG_WIDTH<<S && WIN_Y0 ≤ y_pixel < WIN_Y0+IMG_HEIGHT<<S, with S = SCALE_SHIFT.
- Sync flag: cleared by reset. Set on the first cycle where in_win and (x_pixel, y_pixel) = (WIN_X0, WIN_Y0). While clear, treat in_win as 0.
- Counters, updated only on effective in_win cycles:
  - sub_x: S-bit counter. col increments when sub_x wraps.
  - col: 0..IMG_WIDTH-1.
  - sub_y: S-bit counter, increments after the last window pixel of a line.
  - row_base: advances by IMG_WIDTH each time sub_y wraps.
- At the window's first pixel of each line, sub_x and col restart from 0.
- At (WIN_X0, WIN_Y0), row_base and sub_y are loaded with 0.
- Address invariant: fb_addr = ((y_pixel-WIN_Y0)>>S)*IMG_WIDTH + ((x_pixel-WIN_X0)>>S). Use no multiplier; derive it from the counters.
- x_local = col; y_local = row index (row_base/IMG_WIDTH, kept as a separate counter).
- Outside the window or while unsynced:
  - fb_rd_en = 0, fb_addr holds its last value.
  - Output RGB = 0, win_valid = 0, x_local/y_local = 0.
- Colour conversion: r = rdata[15:12], g = rdata[10:7], b = rdata[4:1].

## Timing
- Stage 1 (cycle N+1): registered fb_addr, fb_rd_en, coordinates, in_win, syncs.
- Stage 2 (cycle N+2): RGB registered from fb_rdata; coordinates, win_valid and syncs delayed one more cycle.
- Total latency from x_pixel/y_pixel/DE to all outputs: exactly 2 cycles, for every pixel including out-of-window pixels.
- Reset: all outputs 0 on the cycle after reset is sampled high, including h_sync_o/v_sync_o.
- Reset mid-frame: block is unsynced, so no reads and win_valid = 0 until the next (WIN_X0, WIN_Y0) pixel. Pipeline contents are flushed to 0.
- DE dropping inside the geometric window counts as out-of-window. Counters do not advance on that cycle.
- Window edge at the display edge (e.g. WIN_X0 + IMG_WIDTH<<S = 640) must work with no wrap past the last column.
- Last pixel of the window produces fb_addr = IMG_WIDTH*IMG_HEIGHT-1. Counters then hold until the next frame load.

## Structure
- Shared package `filter_pkg` holds:
  - IMG_WIDTH / IMG_HEIGHT defaults
  - `rgb444_t` and `rgb565_t` typedefs
  - RGB565→444 conversion function
  - ADDR_W derivation
- Sub-module `pipe_delay #(WIDTH, DEPTH)`: register chain used for the sync, coordinate and win_valid alignment.

## Test plan
- Reset held 3 cycles, then released with DE=0 → all outputs 0; fb_rd_en never asserted.
- Pixel (WIN_X0, WIN_Y0), DE=1, fb_rdata=16'hF800 → fb_addr=0 and fb_rd_en=1 at N+1; at N+2, r/g/b=F/0/0, x_local=0, y_local=0, win_valid=1.
- S=1, rows WIN_Y0+1 and WIN_Y0+2, x = WIN_X0+0..3:
  - row WIN_Y0+1 → addresses 0,0,1,1
  - row WIN_Y0+2 → addresses 160,160,161,161
  - y_local 0 then 1
- Pixel (WIN_X0+319, WIN_Y0+239) → fb_addr=19199, x_local=159, y_local=119. Next pixel → win_valid=0, RGB=0, fb_rd_en=0.
- DE=0 on one in-window cycle → that output is black and no read occurs. Next pixel's address continues unchanged from the previous in-window pixel's sequence.
- Reset asserted mid-window at y=WIN_Y0+50 → no reads for the rest of the frame. The next frame starts at fb_addr=0, and a full frame matches the address formula.
